// File: rtl/tb_mem_arbiter_pkg.sv
// Shared types and widths for the two-master picorv32 memory arbiter.
package tb_mem_arbiter_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int STRB_W      = 4;
  localparam int NUM_MASTERS = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef logic master_idx_t;

  // Round-robin pick: on a tie the master that did not go last wins.
  function automatic master_idx_t rr_pick(input logic [NUM_MASTERS-1:0] valid,
                                          input master_idx_t last);
    if (valid[0] && valid[1]) begin
      return ~last;
    end
    return valid[1] ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/tb_mem_arbiter_picorv32.sv
// Two picorv32-native masters sharing one downstream memory port, round-robin,
// one outstanding transaction, with per-master counters and sticky error flags.
module tb_mem_arbiter_picorv32
  import tb_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   m0_valid,
  input  logic                   m0_instr,
  input  logic [ADDR_W-1:0]      m0_addr,
  input  logic [DATA_W-1:0]      m0_wdata,
  input  logic [STRB_W-1:0]      m0_wstrb,
  output logic                   m0_ready,
  output logic [DATA_W-1:0]      m0_rdata,
  input  logic                   m1_valid,
  input  logic                   m1_instr,
  input  logic [ADDR_W-1:0]      m1_addr,
  input  logic [DATA_W-1:0]      m1_wdata,
  input  logic [STRB_W-1:0]      m1_wstrb,
  output logic                   m1_ready,
  output logic [DATA_W-1:0]      m1_rdata,
  output logic                   s_valid,
  output logic                   s_instr,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [DATA_W-1:0]      s_wdata,
  output logic [STRB_W-1:0]      s_wstrb,
  input  logic                   s_ready,
  input  logic [DATA_W-1:0]      s_rdata,
  output logic                   grant_owner,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] m0_count,
  output logic [COUNT_WIDTH-1:0] m1_count,
  output logic                   protocol_error,
  output logic                   timeout_error
);

  logic [NUM_MASTERS-1:0] m_valid;
  logic [NUM_MASTERS-1:0] m_instr;
  logic [NUM_MASTERS-1:0] m_ready;
  logic [ADDR_W-1:0]      m_addr    [NUM_MASTERS];
  logic [DATA_W-1:0]      m_wdata   [NUM_MASTERS];
  logic [STRB_W-1:0]      m_wstrb   [NUM_MASTERS];
  logic [DATA_W-1:0]      m_rdata   [NUM_MASTERS];
  logic [COUNT_WIDTH-1:0] count_reg [NUM_MASTERS];

  state_t      state_reg;
  master_idx_t owner_reg;
  master_idx_t last_grant_reg;
  logic [31:0] wait_cnt_reg;
  logic        protocol_error_reg;
  logic        timeout_error_reg;
  logic        owner_valid;
  logic        complete;

  assign m_valid    = {m1_valid, m0_valid};
  assign m_instr    = {m1_instr, m0_instr};
  assign m_addr[0]  = m0_addr;
  assign m_addr[1]  = m1_addr;
  assign m_wdata[0] = m0_wdata;
  assign m_wdata[1] = m1_wdata;
  assign m_wstrb[0] = m0_wstrb;
  assign m_wstrb[1] = m1_wstrb;

  assign busy        = (state_reg == BUSY);
  assign owner_valid = m_valid[owner_reg];
  assign complete    = busy && s_ready;

  assign s_valid = busy && owner_valid;
  assign s_instr = m_instr[owner_reg];
  assign s_addr  = m_addr[owner_reg];
  assign s_wdata = m_wdata[owner_reg];
  assign s_wstrb = m_wstrb[owner_reg];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign m_ready[gi] = complete && (owner_reg == master_idx_t'(gi));
      assign m_rdata[gi] = m_ready[gi] ? s_rdata : '0;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          count_reg[gi] <= '0;
        end else if (m_ready[gi]) begin
          count_reg[gi] <= count_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign m0_ready       = m_ready[0];
  assign m1_ready       = m_ready[1];
  assign m0_rdata       = m_rdata[0];
  assign m1_rdata       = m_rdata[1];
  assign m0_count       = count_reg[0];
  assign m1_count       = count_reg[1];
  assign grant_owner    = owner_reg;
  assign protocol_error = protocol_error_reg;
  assign timeout_error  = timeout_error_reg;

  // Every transaction returns through IDLE, so a trailing ready from a
  // registered-ready memory lands on a cycle where s_ready is ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg          <= IDLE;
      owner_reg          <= 1'b0;
      last_grant_reg     <= 1'b1;
      wait_cnt_reg       <= '0;
      protocol_error_reg <= 1'b0;
      timeout_error_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|m_valid) begin
            owner_reg    <= rr_pick(m_valid, last_grant_reg);
            state_reg    <= BUSY;
            wait_cnt_reg <= '0;
          end
        end
        BUSY: begin
          if (s_ready) begin
            last_grant_reg <= owner_reg;
            state_reg      <= IDLE;
            wait_cnt_reg   <= '0;
          end else if (!owner_valid) begin
            protocol_error_reg <= 1'b1;
            last_grant_reg     <= owner_reg;
            state_reg          <= IDLE;
            wait_cnt_reg       <= '0;
          end else if (wait_cnt_reg != TIMEOUT_CYCLES) begin
            // Saturating count; a zero limit never advances and never flags.
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
            if (wait_cnt_reg + 32'd1 == TIMEOUT_CYCLES) begin
              timeout_error_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_mem_arbiter_picorv32.sv
// Directed bench for the two-master arbiter: transaction-level model checked
// every cycle, plus literal expectations for the individual scenarios.
module tb_tb_mem_arbiter_picorv32;

  localparam int TMO = 8;
  localparam int RAM_NORMAL = 0, RAM_STALE = 1, RAM_NEVER = 2, RAM_FORCED = 3;

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          hold;
  } req_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        mv [2];
  logic        mi [2];
  logic [31:0] ma [2];
  logic [31:0] mwd [2];
  logic [3:0]  mws [2];
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = 32'h0;

  logic        m0_ready, m1_ready, s_valid, s_instr, grant_owner, busy;
  logic        protocol_error, timeout_error;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, m0_count, m1_count;
  logic [3:0]  s_wstrb;

  tb_mem_arbiter_picorv32 #(.TIMEOUT_CYCLES(TMO), .COUNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .m0_valid(mv[0]), .m0_instr(mi[0]), .m0_addr(ma[0]), .m0_wdata(mwd[0]),
    .m0_wstrb(mws[0]), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(mv[1]), .m1_instr(mi[1]), .m1_addr(ma[1]), .m1_wdata(mwd[1]),
    .m1_wstrb(mws[1]), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant_owner(grant_owner), .busy(busy),
    .m0_count(m0_count), .m1_count(m1_count),
    .protocol_error(protocol_error), .timeout_error(timeout_error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit check_en = 0;

  // Transaction-level model of the arbiter
  int md_cur, md_last, md_gown, md_wait;
  int md_cnt [2];
  bit md_perr, md_terr;
  int glog[$];
  int gcyc[$];

  // Master stimulus and memory environment
  req_t        reqs [2][16];
  int          head [2];
  int          tail [2];
  int          held [2];
  logic [31:0] mem [0:255];
  int          ram_mode = RAM_NORMAL;
  logic        force_ready = 1'b0;
  logic        sv_s = 1'b0, sr_s = 1'b0;
  logic [31:0] sa_s = 32'h0, swd_s = 32'h0;
  logic [3:0]  sws_s = 4'h0;
  logic        rdy_seen [2];
  int          m1_pulses = 0, m1_idle_pulses = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_cur = -1; md_last = 1; md_gown = 0; md_wait = 0;
    md_cnt[0] = 0; md_cnt[1] = 0; md_perr = 0; md_terr = 0;
  endtask

  task automatic model_step();
    int p;
    if (md_cur < 0) begin
      if (mv[0] || mv[1]) begin
        if (mv[0] && mv[1]) p = 1 - md_last;
        else p = mv[1] ? 1 : 0;
        md_cur = p; md_gown = p; md_wait = 0;
        glog.push_back(p);
        gcyc.push_back(cyc + 1);
      end
    end else if (s_ready) begin
      md_cnt[md_cur]++; md_last = md_cur; md_cur = -1;
    end else if (!mv[md_cur]) begin
      md_perr = 1; md_last = md_cur; md_cur = -1;
    end else if (md_wait < TMO) begin
      md_wait++;
      if (md_wait == TMO) md_terr = 1;
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 2; i++) begin
      head[i] = 0; tail[i] = 0; held[i] = 0;
      mv[i] = 0; mi[i] = 0; ma[i] = 0; mwd[i] = 0; mws[i] = 0;
    end
    s_ready = 0; force_ready = 0;
  endtask

  task automatic push(input int i, input logic ins, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] ws, input int hold);
    reqs[i][tail[i]].instr = ins;
    reqs[i][tail[i]].addr  = a;
    reqs[i][tail[i]].wdata = wd;
    reqs[i][tail[i]].wstrb = ws;
    reqs[i][tail[i]].hold  = hold;
    tail[i]++;
  endtask

  task automatic drive();
    logic nr;
    case (ram_mode)
      RAM_NORMAL: nr = sv_s && !sr_s;
      RAM_STALE:  nr = sv_s;
      RAM_NEVER:  nr = 1'b0;
      default:    nr = force_ready;
    endcase
    if (nr && sv_s) begin
      for (int b = 0; b < 4; b++)
        if (sws_s[b]) mem[sa_s[9:2]][8*b +: 8] = swd_s[8*b +: 8];
      s_rdata = mem[sa_s[9:2]];
    end
    s_ready = nr;
    for (int i = 0; i < 2; i++) begin
      if (head[i] < tail[i]) begin
        if (rdy_seen[i] || (reqs[i][head[i]].hold != 0 && held[i] >= reqs[i][head[i]].hold)) begin
          head[i]++; held[i] = 0;
        end
      end
      if (head[i] < tail[i]) begin
        mv[i] = 1; mi[i] = reqs[i][head[i]].instr; ma[i] = reqs[i][head[i]].addr;
        mwd[i] = reqs[i][head[i]].wdata; mws[i] = reqs[i][head[i]].wstrb;
        held[i]++;
      end else begin
        mv[i] = 0;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      if (!reset) model_step();
      cyc++;
      #1;
      drive();
    end
  endtask

  task automatic run_until_done(input string nm, input int budget);
    int n = 0;
    while ((head[0] < tail[0] || head[1] < tail[1] || md_cur >= 0) && n < budget) begin
      run_cycles(1);
      n++;
    end
    chk({nm, "_budget"}, (n < budget), 1);
  endtask

  task automatic apply_reset();
    @(posedge clock); #2;
    reset = 1; model_reset(); clear_stim();
    @(posedge clock); @(posedge clock); #2;
    reset = 0;
  endtask

  // Per-cycle comparison against the model; also samples what the memory and
  // masters react to on the next edge.
  always @(negedge clock) begin
    bit e_busy, e_sv, e_r0, e_r1;
    sv_s = s_valid; sa_s = s_addr; swd_s = s_wdata; sws_s = s_wstrb; sr_s = s_ready;
    rdy_seen[0] = m0_ready; rdy_seen[1] = m1_ready;
    if (m1_ready) m1_pulses++;
    if (m1_ready && !busy) m1_idle_pulses++;
    if (m0_ready || m1_ready)
      $display("txn m%0d addr=%h wstrb=%h rdata=%h", m1_ready ? 1 : 0, s_addr, s_wstrb, s_rdata);
    if (check_en && !reset) begin
      e_busy = (md_cur >= 0);
      e_sv = 0; e_r0 = 0; e_r1 = 0;
      if (e_busy) begin
        e_sv = mv[md_cur];
        e_r0 = (md_cur == 0) && s_ready;
        e_r1 = (md_cur == 1) && s_ready;
      end
      chk("busy", busy, e_busy);
      chk("s_valid", s_valid, e_sv);
      chk("m0_ready", m0_ready, e_r0);
      chk("m1_ready", m1_ready, e_r1);
      chk("grant_owner", grant_owner, md_gown);
      chk("m0_count", m0_count, 32'(md_cnt[0]));
      chk("m1_count", m1_count, 32'(md_cnt[1]));
      chk("protocol_error", protocol_error, md_perr);
      chk("timeout_error", timeout_error, md_terr);
      if (e_busy && s_ready) begin
        chk("m0_rdata", m0_rdata, e_r0 ? s_rdata : 32'h0);
        chk("m1_rdata", m1_rdata, e_r1 ? s_rdata : 32'h0);
      end
      if (e_sv) begin
        chk("s_addr", s_addr, ma[md_cur]);
        chk("s_wdata", s_wdata, mwd[md_cur]);
        chk("s_wstrb", s_wstrb, mws[md_cur]);
        chk("s_instr", s_instr, mi[md_cur]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[8'h40] = 32'hDEADBEEF;
    mem[8'h80] = 32'h0;
    mem[8'h81] = 32'h0;
    rdy_seen[0] = 0; rdy_seen[1] = 0;
    model_reset(); clear_stim();
    reset = 1;
    #6;
    chk("rst_busy", busy, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_m0_ready", m0_ready, 0);
    chk("rst_m1_ready", m1_ready, 0);
    chk("rst_grant_owner", grant_owner, 0);
    chk("rst_m0_count", m0_count, 0);
    chk("rst_m1_count", m1_count, 0);
    chk("rst_perr", protocol_error, 0);
    chk("rst_terr", timeout_error, 0);
    @(posedge clock); #2;
    reset = 0;
    check_en = 1;

    // Single read from m0 with a one-cycle-ready memory
    ram_mode = RAM_NORMAL; m1_pulses = 0;
    push(0, 1'b0, 32'h100, 32'h0, 4'h0, 0);
    run_cycles(1); @(negedge clock);
    chk("t1_c0_s_valid", s_valid, 0);
    run_cycles(1); @(negedge clock);
    chk("t1_c1_s_valid", s_valid, 1);
    chk("t1_c1_s_addr", s_addr, 32'h100);
    run_cycles(1); @(negedge clock);
    chk("t1_c2_m0_ready", m0_ready, 1);
    chk("t1_c2_m0_rdata", m0_rdata, 32'hDEADBEEF);
    run_cycles(1); @(negedge clock);
    chk("t1_c3_busy", busy, 0);
    chk("t1_c3_m0_count", m0_count, 1);
    run_cycles(2);
    chk("t1_m1_pulses", m1_pulses, 0);

    // Contention: both masters keep requesting
    apply_reset();
    ram_mode = RAM_NORMAL;
    glog.delete(); gcyc.delete();
    push(0, 1'b0, 32'h100, 32'h0, 4'h0, 0);
    push(0, 1'b1, 32'h104, 32'h0, 4'h0, 0);
    push(1, 1'b0, 32'h108, 32'h0, 4'h0, 0);
    push(1, 1'b1, 32'h10C, 32'h0, 4'h0, 0);
    run_until_done("t2", 60);
    run_cycles(2);
    chk("t2_grants", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("t2_g0", glog[0], 0);
      chk("t2_g1", glog[1], 1);
      chk("t2_g2", glog[2], 0);
      chk("t2_g3", glog[3], 1);
      for (int k = 0; k < 3; k++) chk("t2_gap", gcyc[k+1] - gcyc[k], 3);
    end
    chk("t2_m0_count", m0_count, 2);
    chk("t2_m1_count", m1_count, 2);

    // Registered-ready memory producing a stale ready after valid drops
    apply_reset();
    ram_mode = RAM_STALE; m1_pulses = 0; m1_idle_pulses = 0;
    push(1, 1'b0, 32'h200, 32'h0000_00A5, 4'b0001, 0);
    push(1, 1'b0, 32'h204, 32'h0000_00A5, 4'b0001, 0);
    run_until_done("t3", 40);
    run_cycles(3);
    chk("t3_m1_count", m1_count, 2);
    chk("t3_m1_pulses", m1_pulses, 2);
    chk("t3_idle_pulses", m1_idle_pulses, 0);
    chk("t3_mem0", mem[8'h80], 32'h0000_00A5);
    chk("t3_mem1", mem[8'h81], 32'h0000_00A5);

    // m1 abandons its request one cycle after the grant
    apply_reset();
    ram_mode = RAM_NEVER;
    push(1, 1'b0, 32'h300, 32'h0, 4'h0, 2);
    run_cycles(2); @(negedge clock);
    chk("t4_c1_owner", grant_owner, 1);
    chk("t4_c1_busy", busy, 1);
    run_cycles(2); @(negedge clock);
    chk("t4_c3_perr", protocol_error, 1);
    chk("t4_c3_busy", busy, 0);
    chk("t4_c3_m1_count", m1_count, 0);
    ram_mode = RAM_NORMAL;
    push(0, 1'b1, 32'h100, 32'h0, 4'h0, 0);
    run_until_done("t4", 30);
    run_cycles(2);
    chk("t4_m0_count", m0_count, 1);
    chk("t4_m1_count", m1_count, 0);
    chk("t4_perr_sticky", protocol_error, 1);

    // Slow memory: timeout flags after 8 waiting cycles, late ready completes
    ram_mode = RAM_FORCED; force_ready = 0;
    push(0, 1'b0, 32'h100, 32'h0, 4'h0, 0);
    run_cycles(1);
    run_cycles(8); @(negedge clock);
    chk("t5_c8_terr", timeout_error, 0);
    run_cycles(1); @(negedge clock);
    chk("t5_c9_terr", timeout_error, 1);
    chk("t5_c9_busy", busy, 1);
    run_cycles(1);
    force_ready = 1;
    run_cycles(1); @(negedge clock);
    chk("t5_c11_m0_ready", m0_ready, 1);
    chk("t5_c11_m0_rdata", m0_rdata, 32'hDEADBEEF);
    force_ready = 0;
    run_cycles(3);
    chk("t5_m0_count", m0_count, 2);
    chk("t5_busy", busy, 0);
    chk("t5_terr_sticky", timeout_error, 1);

    // Reset asserted between edges while a completion is in progress
    ram_mode = RAM_FORCED; force_ready = 0;
    push(0, 1'b0, 32'h104, 32'h0, 4'h0, 0);
    run_cycles(3);
    force_ready = 1;
    run_cycles(1);
    #1;
    chk("t6_pre_m0_ready", m0_ready, 1);
    chk("t6_pre_s_valid", s_valid, 1);
    #1;
    reset = 1;
    #1;
    chk("t6_s_valid", s_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_m0_ready", m0_ready, 0);
    chk("t6_m0_count", m0_count, 0);
    chk("t6_perr", protocol_error, 0);
    chk("t6_terr", timeout_error, 0);
    model_reset(); clear_stim();
    @(posedge clock); @(posedge clock); #2;
    reset = 0;
    run_cycles(2);
    chk("t6_post_m0_count", m0_count, 0);
    chk("t6_post_m1_count", m1_count, 0);
    chk("t6_post_perr", protocol_error, 0);
    chk("t6_post_terr", timeout_error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
